// File: rtl/hamming15_dec.sv
// Two-stage pipelined Hamming(15,11) decoder, optionally SECDED via overall parity on bit 0.
// Valid/ready on both sides, with saturating correction/detection statistics.
module hamming15_dec #(
  parameter bit CHECK_P0 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] code_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] data_out,
  output logic        corrected,
  output logic        uncorrectable,
  output logic [3:0]  err_pos,
  input  logic        clr_cnt,
  output logic [15:0] corr_cnt,
  output logic [15:0] uncorr_cnt
);

  function automatic logic [3:0] calc_syndrome(input logic [15:0] code);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i < 16; i++) begin
      if (code[i]) s ^= 4'(i);
    end
    return s;
  endfunction

  function automatic logic [10:0] extract_data(input logic [15:0] code);
    return {code[15:9], code[7:5], code[3]};
  endfunction

  // Stage 1: raw codeword plus syndrome and overall parity
  logic        s1_valid_q;
  logic [15:0] s1_code_q;
  logic [3:0]  s1_syn_q;
  logic        s1_par_q;

  // Stage 2: decoded result presented on the outputs
  logic        s2_valid_q;
  logic [10:0] s2_data_q;
  logic        s2_corr_q;
  logic        s2_uncorr_q;
  logic [3:0]  s2_pos_q;

  logic [15:0] corr_cnt_q;
  logic [15:0] uncorr_cnt_q;

  logic        s2_adv;
  logic        s1_load;
  logic        out_fire;

  assign out_fire = s2_valid_q && out_ready;
  assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !reset && (!s1_valid_q || s2_adv);
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
      s1_code_q  <= code_in;
      s1_syn_q   <= calc_syndrome(code_in);
      s1_par_q   <= ^code_in;
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  logic        fix;
  logic        corr_d;
  logic        uncorr_d;
  logic [15:0] fixed_code;

  always_comb begin
    fix      = 1'b0;
    corr_d   = 1'b0;
    uncorr_d = 1'b0;
    if (CHECK_P0) begin
      if (s1_syn_q != 4'd0 && s1_par_q) begin
        fix    = 1'b1;
        corr_d = 1'b1;
      end else if (s1_syn_q == 4'd0 && s1_par_q) begin
        // Only the overall parity bit flipped; data is already good
        corr_d = 1'b1;
      end else if (s1_syn_q != 4'd0) begin
        uncorr_d = 1'b1;
      end
    end else if (s1_syn_q != 4'd0) begin
      fix    = 1'b1;
      corr_d = 1'b1;
    end
    fixed_code = s1_code_q;
    if (fix) fixed_code[s1_syn_q] = ~s1_code_q[s1_syn_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_corr_q   <= 1'b0;
      s2_uncorr_q <= 1'b0;
      s2_pos_q    <= '0;
    end else if (s2_adv) begin
      s2_valid_q  <= 1'b1;
      s2_data_q   <= extract_data(fixed_code);
      s2_corr_q   <= corr_d;
      s2_uncorr_q <= uncorr_d;
      s2_pos_q    <= s1_syn_q;
    end else if (out_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (out_fire) begin
      if (s2_corr_q && corr_cnt_q != 16'hFFFF) corr_cnt_q <= corr_cnt_q + 16'd1;
      if (s2_uncorr_q && uncorr_cnt_q != 16'hFFFF) uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
    end
  end

  assign out_valid     = s2_valid_q;
  assign data_out      = s2_data_q;
  assign corrected     = s2_corr_q;
  assign uncorrectable = s2_uncorr_q;
  assign err_pos       = s2_pos_q;
  assign corr_cnt      = corr_cnt_q;
  assign uncorr_cnt    = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming15_dec.sv
// Directed bench for hamming15_dec: SECDED and SEC-only instances share one stimulus stream.
module tb_hamming15_dec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] code_in;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready, out_valid, corrected, uncorrectable;
  logic [10:0] data_out;
  logic [3:0]  err_pos;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        b_in_ready, b_out_valid, b_corrected, b_uncorrectable;
  logic [10:0] b_data_out;
  logic [3:0]  b_err_pos;
  logic [15:0] b_corr_cnt, b_uncorr_cnt;

  int n_vec = 0;
  int n_bad = 0;

  hamming15_dec #(.CHECK_P0(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .corrected(corrected),
    .uncorrectable(uncorrectable), .err_pos(err_pos), .clr_cnt(clr_cnt),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming15_dec #(.CHECK_P0(1'b0)) dut_sec (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .code_in(code_in),
    .out_valid(b_out_valid), .out_ready(out_ready), .data_out(b_data_out),
    .corrected(b_corrected), .uncorrectable(b_uncorrectable), .err_pos(b_err_pos),
    .clr_cnt(clr_cnt), .corr_cnt(b_corr_cnt), .uncorr_cnt(b_uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word, then check it is not yet valid after the first edge
  task automatic launch(input logic [15:0] code, input string tag);
    in_valid  = 1'b1;
    code_in   = code;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; code_in = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data", data_out, 11'h000);
    chk("rst_flags", {corrected, uncorrectable, err_pos}, 6'h00);
    chk("rst_cnts", {corr_cnt, uncorr_cnt}, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Clean word
    launch(16'h1D8B, "clean");
    chk("clean_data", data_out, 11'h0E9);
    chk("clean_flags", {corrected, uncorrectable, err_pos}, 6'h00);
    chk("clean_sec", {b_data_out, b_corrected, b_err_pos}, {11'h0E9, 1'b0, 4'd0});
    tick();
    chk("clean_drained", out_valid, 1'b0);
    chk("clean_cnt", corr_cnt, 16'd0);

    // Single error at position 10
    launch(16'h198B, "single");
    chk("single_data", data_out, 11'h0E9);
    chk("single_flags", {corrected, uncorrectable, err_pos}, {1'b1, 1'b0, 4'd10});
    tick();
    chk("single_cnt", {corr_cnt, uncorr_cnt}, {16'd1, 16'd0});

    // Double error, positions 10 and 3
    launch(16'h1983, "double");
    chk("double_data", data_out, 11'h0C8);
    chk("double_flags", {corrected, uncorrectable, err_pos}, {1'b0, 1'b1, 4'd9});
    chk("double_sec_data", b_data_out, 11'h0D8);
    chk("double_sec_flags", {b_corrected, b_uncorrectable, b_err_pos}, {1'b1, 1'b0, 4'd9});
    tick();
    chk("double_cnt", {corr_cnt, uncorr_cnt}, {16'd1, 16'd1});
    chk("double_sec_cnt", {b_corr_cnt, b_uncorr_cnt}, {16'd2, 16'd0});

    // Overall parity bit only
    launch(16'h1D8A, "p0err");
    chk("p0err_data", data_out, 11'h0E9);
    chk("p0err_flags", {corrected, uncorrectable, err_pos}, {1'b1, 1'b0, 4'd0});
    chk("p0err_sec_flags", {b_corrected, b_data_out}, {1'b0, 11'h0E9});
    tick();
    chk("p0err_cnt", corr_cnt, 16'd2);

    // Back-to-back under stall: A=clean E9, B=double C8, C=zero word
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = 16'h1D8B;
    tick();
    chk("stall_rdy_a", in_ready, 1'b1);
    code_in = 16'h1983;
    tick();
    chk("stall_rdy_b", in_ready, 1'b0);
    code_in = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_hold", {out_valid, in_ready, data_out, uncorrectable, err_pos},
          {1'b1, 1'b0, 11'h0E9, 1'b0, 4'd0});
    end
    out_ready = 1'b1;
    #1;
    chk("release_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("order_b", {out_valid, data_out, uncorrectable, err_pos}, {1'b1, 11'h0C8, 1'b1, 4'd9});
    tick();
    chk("order_c", {out_valid, data_out, uncorrectable, err_pos}, {1'b1, 11'h000, 1'b0, 4'd0});
    tick();
    chk("order_end", out_valid, 1'b0);
    chk("stall_cnt", {corr_cnt, uncorr_cnt}, {16'd2, 16'd2});

    // Clear coincident with a corrected-word handshake
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = 16'h198B;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_pending", {out_valid, corrected}, 2'b11);
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_win", {corr_cnt, uncorr_cnt}, 32'h0);
    chk("clr_sec", {b_corr_cnt, b_uncorr_cnt}, 32'h0);

    // Saturation: 65535 corrected words, then one more
    in_valid = 1'b1;
    code_in  = 16'h198B;
    for (int i = 0; i < 65535; i++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_reach", corr_cnt, 16'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_hold", corr_cnt, 16'hFFFF);
    chk("sat_sec_hold", b_corr_cnt, 16'hFFFF);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = 16'h198B;
    tick();
    tick();
    chk("full_pre", {out_valid, in_ready}, 2'b10);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    chk("full_rst", {out_valid, in_ready, corrected, err_pos}, 7'h00);
    chk("full_rst_cnt", {corr_cnt, uncorr_cnt}, 32'h0);
    reset = 1'b0;
    #1;
    chk("full_rst_rdy", in_ready, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("full_discard", {out_valid, corr_cnt}, 17'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
